// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and its line
// synchroniser. Holds the transmitter state encoding, common keyboard
// command bytes, device reply codes, frame bit-count limits and the parity
// helper used when a byte is latched for sending.
package ps2_pkg;

    // Transmitter state encoding
    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE      = 3'd0;
    localparam tx_state_t ST_INHIBIT   = 3'd1;
    localparam tx_state_t ST_REQ       = 3'd2;
    localparam tx_state_t ST_DATA      = 3'd3;
    localparam tx_state_t ST_ACK       = 3'd4;
    localparam tx_state_t ST_WAIT_IDLE = 3'd5;
    localparam tx_state_t ST_FAIL      = 3'd6;

    // Host-to-keyboard command bytes
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;

    // Keyboard reply codes
    localparam logic [7:0] ACK_CODE = 8'hFA;
    localparam logic [7:0] BAT_OK   = 8'hAA;

    // Bit count after each device falling edge: fall 1 leaves 1, fall 9
    // (parity presented) leaves 9, fall 10 (stop) leaves 10, fall 11 (ACK) 11.
    localparam int unsigned BITCNT_W     = 4;
    localparam logic [3:0]  BITCNT_FIRST = 4'd1;
    localparam logic [3:0]  BITCNT_STOP  = 4'd9;
    localparam logic [3:0]  BITCNT_ACK   = 4'd10;
    localparam logic [3:0]  BITCNT_DONE  = 4'd11;

    // Odd parity: the 9-bit {parity, data} word always has an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the asynchronous PS/2 clock and data pad levels into
// the system clock domain through two flops each, and produces a one-cycle
// pulse for every falling edge of the synchronised PS/2 clock. Shared by the
// PS/2 receiver and the host transmitter.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset (lines assumed idle high)
//   psclk_i     PS/2 clock pad level
//   psdata_i    PS/2 data pad level
//   clk_sync_o  synchronised PS/2 clock
//   data_sync_o synchronised PS/2 data
//   fall_o      one-cycle pulse per PS/2 clock falling edge
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic psclk_i,
    input  logic psdata_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic fall_o
);

    logic [1:0] clk_ff_d, clk_ff_q;
    logic [1:0] data_ff_d, data_ff_q;
    logic       prev_clk_d, prev_clk_q;

    always_comb begin
        clk_ff_d   = {clk_ff_q[0], psclk_i};
        data_ff_d  = {data_ff_q[0], psdata_i};
        prev_clk_d = clk_ff_q[1];
    end

    // Reset to 1s so an idle bus does not produce a spurious edge at reset exit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_ff_q   <= 2'b11;
            data_ff_q  <= 2'b11;
            prev_clk_q <= 1'b1;
        end else begin
            clk_ff_q   <= clk_ff_d;
            data_ff_q  <= data_ff_d;
            prev_clk_q <= prev_clk_d;
        end
    end

    assign clk_sync_o  = clk_ff_q[1];
    assign data_sync_o = data_ff_q[1];
    assign fall_o      = prev_clk_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the bus, issues a
// request-to-send, then shifts start/data/parity/stop out on device clock
// falling edges and checks the device ACK. Lines are driven open-drain.
//   clk50       system clock
//   reset       asynchronous active-low reset
//   psclk       PS/2 clock pad level (async)
//   psdata      PS/2 data pad level (async)
//   psclk_low   1 = pull psclk low, 0 = release
//   psdata_low  1 = pull psdata low, 0 = release
//   tx_data     byte to send, sampled when tx_start is accepted
//   tx_start    one-cycle request, accepted only when idle
//   tx_busy     high from accept until the end of the transfer
//   tx_done     one-cycle pulse at the end of every transfer
//   tx_error    one-cycle pulse with tx_done on NACK or timeout
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 5000,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
    parameter int unsigned BIT_TIMEOUT        = 10000,
    parameter int unsigned CNT_W              = 20
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       psclk,
    input  logic       psdata,
    output logic       psclk_low,
    output logic       psdata_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    import ps2_pkg::*;

    // Timer value seen on the last cycle of each interval
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);

    logic clk_sync, data_sync, fall;

    ps2_line_sync u_line_sync (
        .clk_i       (clk50),
        .rst_ni      (reset),
        .psclk_i     (psclk),
        .psdata_i    (psdata),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .fall_o      (fall)
    );

    tx_state_t           state_d, state_q;
    logic [CNT_W-1:0]    timer_d, timer_q, timer_inc;
    logic [BITCNT_W-1:0] bitcnt_d, bitcnt_q;
    logic [8:0]          shift_d, shift_q;
    logic                psclk_low_d, psclk_low_q;
    logic                psdata_low_d, psdata_low_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                error_d, error_q;

    // Saturating increment so a stuck bus can never wrap the timer back into range
    assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + TIMER_ONE;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_inc;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        psclk_low_d  = psclk_low_q;
        psdata_low_d = psdata_low_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d      = '0;
                psclk_low_d  = 1'b0;
                psdata_low_d = 1'b0;
                if (tx_start) begin
                    shift_d     = {odd_parity(tx_data), tx_data};
                    bitcnt_d    = '0;
                    busy_d      = 1'b1;
                    psclk_low_d = 1'b1;
                    state_d     = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    // Start bit goes low in the same cycle the clock is released
                    timer_d      = '0;
                    psclk_low_d  = 1'b0;
                    psdata_low_d = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fall) begin
                    psdata_low_d = ~shift_q[0];
                    shift_d      = {1'b0, shift_q[8:1]};
                    bitcnt_d     = BITCNT_FIRST;
                    timer_d      = '0;
                    state_d      = ST_DATA;
                end else if (timer_q >= FIRST_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    timer_d = '0;
                    if (bitcnt_q == BITCNT_STOP) begin
                        psdata_low_d = 1'b0;
                        bitcnt_d     = BITCNT_ACK;
                        state_d      = ST_ACK;
                    end else begin
                        psdata_low_d = ~shift_q[0];
                        shift_d      = {1'b0, shift_q[8:1]};
                        bitcnt_d     = bitcnt_q + 4'd1;
                    end
                end else if (timer_q >= BIT_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    timer_d  = '0;
                    bitcnt_d = BITCNT_DONE;
                    state_d  = data_sync ? ST_FAIL : ST_WAIT_IDLE;
                end else if (timer_q >= BIT_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    bitcnt_d = '0;
                    timer_d  = '0;
                    state_d  = ST_IDLE;
                end else if (timer_q >= BIT_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: begin
                done_d   = 1'b1;
                error_d  = 1'b1;
                busy_d   = 1'b0;
                bitcnt_d = '0;
                timer_d  = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Any path into FAIL lets go of both lines immediately
        if (state_d == ST_FAIL) begin
            psclk_low_d  = 1'b0;
            psdata_low_d = 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            psclk_low_q  <= 1'b0;
            psdata_low_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            psclk_low_q  <= psclk_low_d;
            psdata_low_q <= psdata_low_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign psclk_low  = psclk_low_q;
    assign psdata_low = psdata_low_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx. A behavioural keyboard
// clocks frames at a 40-cycle period, captures start/data/parity/stop on its
// rising edges and answers with ACK or NACK.
module tb_ps2_host_tx;

    logic       clk50    = 1'b0;
    logic       reset    = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       psclk, psdata;
    logic       psclk_low, psdata_low;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;

    int   n_vec      = 0;
    int   n_err      = 0;
    int   done_cnt   = 0;
    logic last_err   = 1'b0;
    logic prev_done  = 1'b0;
    logic busy_after = 1'b1;

    // Open-drain bus: either side can pull a line low
    assign psclk  = dev_clk & ~psclk_low;
    assign psdata = dev_data & ~psdata_low;

    always #5 clk50 = ~clk50;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (50),
        .FIRST_EDGE_TIMEOUT (400),
        .BIT_TIMEOUT        (200),
        .CNT_W              (20)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .psclk      (psclk),
        .psdata     (psdata),
        .psclk_low  (psclk_low),
        .psdata_low (psdata_low),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    // Count done pulses, remember the error flag and busy the cycle after done
    always @(negedge clk50) begin
        if (tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            last_err <= tx_error;
        end
        if (prev_done) busy_after <= tx_busy;
        prev_done <= tx_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk50);
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk50);
            c++;
        end
        repeat (2) @(negedge clk50);
    endtask

    // Keyboard model. frame[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_frame(input logic nack, input int inject_fall, input int abort_fall,
                             output logic [10:0] frame, output int inhibit_len,
                             output logic ok);
        int n = 0;
        frame       = '0;
        inhibit_len = 0;
        ok          = 1'b1;
        while (psclk_low !== 1'b1 && n < 100) begin
            @(posedge clk50);
            #1;
            n++;
        end
        if (psclk_low !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        while (psclk_low === 1'b1 && inhibit_len < 1000) begin
            @(posedge clk50);
            #1;
            inhibit_len++;
        end
        frame[0] = psdata;
        for (int f = 1; f <= 11; f++) begin
            repeat (15) @(posedge clk50);
            #1;
            if (f == 11) dev_data = nack;
            repeat (5) @(posedge clk50);
            #1;
            dev_clk = 1'b0;
            if (f == inject_fall) begin
                @(negedge clk50);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk50);
                tx_start = 1'b0;
            end
            if (f == abort_fall) begin
                repeat (10) @(posedge clk50);
                #1;
                check("abort_pre_psdata_low", psdata_low, 1);
                #1;
                reset = 1'b0;
                #1;
                check("abort_psclk_low", psclk_low, 0);
                check("abort_psdata_low", psdata_low, 0);
                check("abort_busy", tx_busy, 0);
                dev_clk = 1'b1;
                return;
            end
            repeat (20) @(posedge clk50);
            #1;
            if (f <= 10) begin
                frame[f] = psdata;
                check($sformatf("busy_fall%0d", f), tx_busy, 1);
            end
            dev_clk = 1'b1;
        end
        repeat (5) @(posedge clk50);
        #1;
        dev_data = 1'b1;
    endtask

    initial begin
        logic [10:0] fr;
        int          il;
        logic        ok;
        int          c;
        int          d0;

        // Reset state
        repeat (3) @(negedge clk50);
        check("rst_psclk_low", psclk_low, 0);
        check("rst_psdata_low", psdata_low, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk50);

        // 0xED with ACK
        d0 = done_cnt;
        send(8'hED);
        dev_frame(1'b0, 0, 0, fr, il, ok);
        check("ed_ok", ok, 1);
        check("ed_inhibit_len", il, 50);
        check("ed_frame", fr, 11'b1_1_11101101_0);
        wait_done(d0 + 1, 300);
        check("ed_done_cnt", done_cnt - d0, 1);
        check("ed_error", last_err, 0);
        check("ed_busy_after", busy_after, 0);

        // 0xF4 with ACK
        d0 = done_cnt;
        send(8'hF4);
        dev_frame(1'b0, 0, 0, fr, il, ok);
        check("f4_ok", ok, 1);
        check("f4_frame", fr, 11'b1_0_11110100_0);
        wait_done(d0 + 1, 300);
        check("f4_done_cnt", done_cnt - d0, 1);
        check("f4_error", last_err, 0);
        check("f4_busy_after", busy_after, 0);

        // No device: first-edge timeout
        send(8'h55);
        c = 0;
        while (tx_done !== 1'b1 && c < 1000) begin
            @(negedge clk50);
            c++;
        end
        check("nodev_done", tx_done, 1);
        check("nodev_error", tx_error, 1);
        check("nodev_latency_451_to_453", (c >= 451 && c <= 453), 1);
        @(negedge clk50);
        check("nodev_done_pulse", tx_done, 0);
        check("nodev_psclk_low", psclk_low, 0);
        check("nodev_psdata_low", psdata_low, 0);
        check("nodev_busy", tx_busy, 0);

        // 0xFF with NACK, then a normal send
        d0 = done_cnt;
        send(8'hFF);
        dev_frame(1'b1, 0, 0, fr, il, ok);
        check("ff_frame", fr, 11'b1_1_11111111_0);
        wait_done(d0 + 1, 300);
        check("ff_done_cnt", done_cnt - d0, 1);
        check("ff_error", last_err, 1);
        d0 = done_cnt;
        send(8'hF4);
        dev_frame(1'b0, 0, 0, fr, il, ok);
        check("after_nack_frame", fr, 11'b1_0_11110100_0);
        wait_done(d0 + 1, 300);
        check("after_nack_error", last_err, 0);

        // tx_start mid-frame is ignored
        d0 = done_cnt;
        send(8'hED);
        dev_frame(1'b0, 3, 0, fr, il, ok);
        check("inject_frame", fr, 11'b1_1_11101101_0);
        wait_done(d0 + 1, 300);
        repeat (100) @(negedge clk50);
        check("inject_done_cnt", done_cnt - d0, 1);
        check("inject_no_restart", psclk_low, 0);
        check("inject_busy", tx_busy, 0);

        // Reset during DATA bit 4, then recover
        d0 = done_cnt;
        send(8'hED);
        dev_frame(1'b0, 0, 5, fr, il, ok);
        repeat (3) @(negedge clk50);
        reset = 1'b1;
        repeat (100) @(negedge clk50);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_psclk_low", psclk_low, 0);
        d0 = done_cnt;
        send(8'hF4);
        dev_frame(1'b0, 0, 0, fr, il, ok);
        check("recover_frame", fr, 11'b1_0_11110100_0);
        wait_done(d0 + 1, 300);
        check("recover_done_cnt", done_cnt - d0, 1);
        check("recover_error", last_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
